// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types and constants.
// Holds the fetch FSM encoding and the fetch->decode bundle.
package fetch_unit_pkg;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     raw_instr;
    logic [XLEN-1:0] pc;
    logic            is_bubble;
  } fetch_data_t;

  localparam fetch_data_t BUBBLE = '{
    raw_instr: 32'h0,
    pc:        '0,
    is_bubble: 1'b1
  };

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction bus between fetch and memory.
// Single outstanding request, completed by iresp_data_ok.
interface fetch_unit_if #(
  parameter int XLEN = 64
);
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_unit_pcsel.sv
// fetch_unit_pcsel: redirect qualification and target select.
// Execute wins over decode; nothing redirects while stalled.
module fetch_unit_pcsel #(
  parameter int XLEN = 64
) (
  input  logic            stall,
  input  logic            dec_is_jump,
  input  logic [XLEN-1:0] dec_pc,
  input  logic [XLEN-1:0] dec_offset,
  input  logic            exe_redirect,
  input  logic [XLEN-1:0] exe_target,
  output logic            redir,
  output logic [XLEN-1:0] redir_target
);

  assign redir = !stall && (exe_redirect || dec_is_jump);

  assign redir_target = exe_redirect ? exe_target
                                     : dec_pc + dec_offset;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-bus master of the IF stage.
// Tracks the single outstanding request across redirects and stalls.
module fetch_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  fetch_unit_if.master                ibus,
  input  logic                        stall,
  input  logic                        dec_is_jump,
  input  logic [XLEN-1:0]             dec_pc,
  input  logic [XLEN-1:0]             dec_offset,
  input  logic                        exe_redirect,
  input  logic [XLEN-1:0]             exe_target,
  output fetch_unit_pkg::fetch_data_t dataF
);
  import fetch_unit_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] saved_q, saved_d;
  logic [31:0]     buf_q, buf_d;
  fetch_data_t     data_d;
  logic            redir;
  logic [XLEN-1:0] redir_target;
  logic            ok;

  fetch_unit_pcsel #(.XLEN(XLEN)) u_pcsel (
    .stall        (stall),
    .dec_is_jump  (dec_is_jump),
    .dec_pc       (dec_pc),
    .dec_offset   (dec_offset),
    .exe_redirect (exe_redirect),
    .exe_target   (exe_target),
    .redir        (redir),
    .redir_target (redir_target)
  );

  assign ok              = ibus.iresp_data_ok;
  assign ibus.ireq_valid = (state_q != HOLD);
  assign ibus.ireq_addr  = pc_q;

  // Next state, next PC and the word handed to decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    buf_d   = buf_q;
    data_d  = dataF;
    unique case (state_q)
      FETCH: begin
        if (ok && redir) begin
          pc_d   = redir_target;
          data_d = BUBBLE;
        end else if (ok && stall) begin
          buf_d   = ibus.iresp_data;
          state_d = HOLD;
        end else if (ok) begin
          data_d = '{ibus.iresp_data, pc_q, 1'b0};
          pc_d   = pc_q + 4;
        end else if (redir) begin
          saved_d = redir_target;
          data_d  = BUBBLE;
          state_d = DROP;
        end else if (!stall) begin
          data_d = BUBBLE;
        end
      end
      DROP: begin
        if (redir) saved_d = redir_target;
        if (!stall) data_d = BUBBLE;
        if (ok) begin
          pc_d    = redir ? redir_target : saved_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (redir) begin
            pc_d   = redir_target;
            data_d = BUBBLE;
          end else begin
            data_d = '{buf_q, pc_q, 1'b0};
            pc_d   = pc_q + 4;
          end
        end
      end
      default: ;
    endcase
  end

  // State, PC, buffer and decode-bundle registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      saved_q <= '0;
      buf_q   <= '0;
      dataF   <= BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
      buf_q   <= buf_d;
      dataF   <= data_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for the fetch stage.
// A transaction-level model tracks the expected bus and decode view.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        dec_is_jump;
  logic        exe_redirect;
  logic [63:0] dec_pc;
  logic [63:0] dec_offset;
  logic [63:0] exe_target;
  fetch_data_t dataF;

  fetch_unit_if #(.XLEN(64)) ibus ();

  fetch_unit #(.XLEN(64), .PC_RESET(B)) dut (
    .clk          (clk),
    .reset        (reset),
    .ibus         (ibus),
    .stall        (stall),
    .dec_is_jump  (dec_is_jump),
    .dec_pc       (dec_pc),
    .dec_offset   (dec_offset),
    .exe_redirect (exe_redirect),
    .exe_target   (exe_target),
    .dataF        (dataF)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cnt = 0;
  bit run = 0;
  bit saw_wrong = 0;

  // memory image: every address holds a distinct word
  function automatic logic [31:0] word_of(logic [63:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic fetch_data_t mk(logic [31:0] w,
                                     logic [63:0] p,
                                     logic b);
    fetch_data_t d;
    d.raw_instr = w;
    d.pc        = p;
    d.is_bubble = b;
    return d;
  endfunction

  task automatic chk(input string n,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", n, $time, got, exp);
    end
  endtask

  task automatic wait_addr(input string n, input logic [63:0] a);
    for (int i = 0; i < 20; i++) begin
      if (ibus.ireq_valid === 1'b1 && ibus.ireq_addr === a) break;
      @(negedge clk);
    end
    chk(n, {ibus.ireq_valid, ibus.ireq_addr}, {1'b1, a});
  endtask

  // memory: answers a request after it has been visible lat+1 cycles
  always @(negedge clk) begin
    if (ibus.iresp_data_ok === 1'b1) begin
      ibus.iresp_data_ok = 1'b0;
      cnt = 0;
    end
    if (reset) begin
      ibus.iresp_data_ok = 1'b0;
      ibus.iresp_data    = 32'h0;
      cnt = 0;
    end else if (ibus.ireq_valid) begin
      cnt++;
      if (cnt > lat) begin
        ibus.iresp_data_ok = 1'b1;
        ibus.iresp_data    = word_of(ibus.ireq_addr);
      end
    end
  end

  // model: pc of the live request, wrong-path flag, parked word
  logic [63:0] m_pc, m_after;
  bit          m_wrong, m_held;
  fetch_data_t m_data;

  always @(posedge clk or posedge reset) begin
    bit r;
    logic [63:0] t;
    if (reset) begin
      m_pc    = B;
      m_after = 64'h0;
      m_wrong = 0;
      m_held  = 0;
      m_data  = mk(32'h0, 64'h0, 1'b1);
    end else begin
      r = !stall && (exe_redirect || dec_is_jump);
      t = exe_redirect ? exe_target : dec_pc + dec_offset;
      if (m_held) begin
        if (!stall) begin
          m_held = 0;
          if (r) begin
            m_pc   = t;
            m_data = mk(32'h0, 64'h0, 1'b1);
          end else begin
            m_data = mk(word_of(m_pc), m_pc, 1'b0);
            m_pc   = m_pc + 64'd4;
          end
        end
      end else begin
        if (!stall) m_data = mk(32'h0, 64'h0, 1'b1);
        if (ibus.iresp_data_ok === 1'b1) begin
          if (m_wrong || r) begin
            m_pc    = r ? t : m_after;
            m_wrong = 0;
          end else if (stall) begin
            m_held = 1;
          end else begin
            m_data = mk(word_of(m_pc), m_pc, 1'b0);
            m_pc   = m_pc + 64'd4;
          end
        end else if (r) begin
          m_wrong = 1;
          m_after = t;
        end
      end
    end
  end

  // compare DUT against the model every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        checks++;
        if (ibus.ireq_valid !== !m_held) begin
          errors++;
          $display("FAIL cmp_valid t=%0t got=%b want=%b",
                   $time, ibus.ireq_valid, !m_held);
        end
        if (!m_held) begin
          checks++;
          if (ibus.ireq_addr !== m_pc) begin
            errors++;
            $display("FAIL cmp_addr t=%0t got=%h want=%h",
                     $time, ibus.ireq_addr, m_pc);
          end
        end
        checks++;
        if (dataF !== m_data) begin
          errors++;
          $display("FAIL cmp_dataF t=%0t got=%h want=%h",
                   $time, dataF, m_data);
        end
        if (!dataF.is_bubble && dataF.pc == B + 64'h28)
          saw_wrong = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1; stall = 0; dec_is_jump = 0; exe_redirect = 0;
    dec_pc = 0; dec_offset = 0; exe_target = 0; lat = 1;
    #12;
    chk("reset_dataF", dataF, mk(32'h0, 64'h0, 1'b1));
    @(negedge clk);
    reset = 0;
    run = 1;
    chk("rst_req", {ibus.ireq_valid, ibus.ireq_addr}, {1'b1, B});

    // back-to-back fetches
    wait_addr("seq0", B);
    wait_addr("seq1", B + 64'h4);
    chk("dataF_0", dataF, mk(word_of(B), B, 1'b0));
    wait_addr("seq2", B + 64'h8);
    chk("dataF_4", dataF, mk(word_of(B + 64'h4), B + 64'h4, 1'b0));

    // slow response on 0x10
    wait_addr("seq3", B + 64'h10);
    lat = 3;
    @(negedge clk);
    chk("slow_addr1", ibus.ireq_addr, B + 64'h10);
    chk("slow_bub1", dataF.is_bubble, 1'b1);
    @(negedge clk);
    chk("slow_addr2", ibus.ireq_addr, B + 64'h10);
    chk("slow_bub2", dataF.is_bubble, 1'b1);
    @(negedge clk);
    chk("slow_addr3", ibus.ireq_addr, B + 64'h10);
    wait_addr("after_slow", B + 64'h14);
    chk("slow_data", dataF, mk(word_of(B + 64'h10), B + 64'h10, 1'b0));
    lat = 1;

    // decode jump while 0x28 is outstanding
    wait_addr("at_28", B + 64'h28);
    lat = 2;
    dec_is_jump = 1; dec_pc = B + 64'h20; dec_offset = 64'h40;
    @(negedge clk);
    dec_is_jump = 0;
    chk("drop_hold", ibus.ireq_addr, B + 64'h28);
    wait_addr("jmp_tgt", B + 64'h60);
    chk("no_wrong", saw_wrong, 1'b0);

    // execute beats decode in the same cycle
    lat = 1;
    exe_redirect = 1; exe_target = B + 64'h1000;
    dec_is_jump = 1; dec_pc = B + 64'h60; dec_offset = 64'h100;
    @(negedge clk);
    exe_redirect = 0; dec_is_jump = 0;
    @(negedge clk);
    chk("exe_prio", {ibus.ireq_valid, ibus.ireq_addr},
        {1'b1, B + 64'h1000});

    // steer to 0x2c, then stall as 0x30 returns
    exe_redirect = 1; exe_target = B + 64'h2c;
    @(negedge clk);
    exe_redirect = 0;
    wait_addr("to_2c", B + 64'h2c);
    wait_addr("to_30", B + 64'h30);
    chk("pre_stall", dataF, mk(word_of(B + 64'h2c), B + 64'h2c, 1'b0));
    stall = 1;
    @(negedge clk);
    chk("frz1", dataF, mk(word_of(B + 64'h2c), B + 64'h2c, 1'b0));
    @(negedge clk);
    chk("hold_v2", ibus.ireq_valid, 1'b0);
    chk("frz2", dataF, mk(word_of(B + 64'h2c), B + 64'h2c, 1'b0));
    dec_is_jump = 1; dec_pc = B + 64'h500; dec_offset = 64'h4;
    @(negedge clk);
    chk("hold_v3", ibus.ireq_valid, 1'b0);
    chk("frz3", dataF, mk(word_of(B + 64'h2c), B + 64'h2c, 1'b0));
    @(negedge clk);
    chk("hold_v4", ibus.ireq_valid, 1'b0);
    stall = 0; dec_is_jump = 0;
    @(negedge clk);
    chk("unstall", dataF, mk(word_of(B + 64'h30), B + 64'h30, 1'b0));
    chk("next_34", {ibus.ireq_valid, ibus.ireq_addr},
        {1'b1, B + 64'h34});

    // async reset in the middle of a drop
    lat = 3;
    dec_is_jump = 1; dec_pc = B + 64'h100; dec_offset = 64'h8;
    @(negedge clk);
    dec_is_jump = 0;
    #2 reset = 1;
    #1;
    chk("async_bub", dataF, mk(32'h0, 64'h0, 1'b1));
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    lat = 1;
    chk("rel_req", {ibus.ireq_valid, ibus.ireq_addr}, {1'b1, B});
    wait_addr("post_rst", B + 64'h4);
    chk("post_data", dataF, mk(word_of(B), B, 1'b0));
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
